// File: rtl/channel_in_tree_acc_if.sv
// ============================================================================
// Module      : channel_in_tree_acc_if
// Description : Beat-in / sum-out bundle for the channel-in tree accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface channel_in_tree_acc_if #(
    parameter int COMPUTE_CHANNEL_IN_NUM = 4,
    parameter int LANE_NUM               = 8,
    parameter int LANE_WIDTH             = 32
);
    logic                                                in_valid;
    logic                                                in_first;
    logic                                                in_last;
    logic [COMPUTE_CHANNEL_IN_NUM*LANE_NUM*LANE_WIDTH-1:0] data_in;
    logic                                                out_valid;
    logic [LANE_NUM*LANE_WIDTH-1:0]                      data_out;
    logic                                                sat_flag;

    modport master (
        output in_valid, in_first, in_last, data_in,
        input  out_valid, data_out, sat_flag
    );

    modport slave (
        input  in_valid, in_first, in_last, data_in,
        output out_valid, data_out, sat_flag
    );
endinterface

`default_nettype wire

// File: rtl/channel_in_tree_acc.sv
// ============================================================================
// Module      : channel_in_tree_acc
// Description : Registered adder tree over input channels, then per-lane
//               first/last framed accumulation with optional saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module channel_in_tree_acc #(
    parameter int COMPUTE_CHANNEL_IN_NUM = 4,
    parameter int LANE_NUM               = 8,
    parameter int LANE_WIDTH             = 32,
    parameter int SATURATE               = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    channel_in_tree_acc_if.slave  bus
);
    localparam int c_L     = $clog2(COMPUTE_CHANNEL_IN_NUM);
    localparam int c_SW    = LANE_WIDTH + c_L + 1;
    localparam int c_NLEAF = COMPUTE_CHANNEL_IN_NUM * LANE_NUM;
    localparam logic signed [c_SW-1:0] c_MAX = {{(c_L+2){1'b0}}, {(LANE_WIDTH-1){1'b1}}};
    localparam logic signed [c_SW-1:0] c_MIN = {{(c_L+2){1'b1}}, {(LANE_WIDTH-1){1'b0}}};

    logic signed [c_SW-1:0]       w_leaf    [c_NLEAF];
    logic signed [c_SW-1:0]       w_tree    [LANE_NUM];
    logic                         w_t_vld;
    logic                         w_t_first;
    logic                         w_t_last;
    logic signed [c_SW-1:0]       w_base    [LANE_NUM];
    logic signed [c_SW-1:0]       w_sum     [LANE_NUM];
    logic [LANE_WIDTH-1:0]        w_acc_nxt [LANE_NUM];
    logic                         w_clamp;
    logic signed [LANE_WIDTH-1:0] r_acc     [LANE_NUM];
    logic                         r_sat;
    logic                         r_done;

    always_comb begin
        for (int i = 0; i < c_NLEAF; i++) begin
            w_leaf[i] = c_SW'($signed(bus.data_in[i*LANE_WIDTH +: LANE_WIDTH]));
        end
    end

    generate
        if (c_L > 0) begin : g_tree
            // Levels 1..L packed back to back; level lv starts at node CIN - 2*(CIN>>lv).
            logic signed [c_SW-1:0] r_node [(COMPUTE_CHANNEL_IN_NUM-1)*LANE_NUM];
            logic [c_L-1:0]         r_vld;
            logic [c_L-1:0]         r_first;
            logic [c_L-1:0]         r_last;

            function automatic int node_idx(input int lv, input int k, input int p);
                return (COMPUTE_CHANNEL_IN_NUM - 2*(COMPUTE_CHANNEL_IN_NUM >> lv) + k) * LANE_NUM + p;
            endfunction

            always_ff @(posedge clk) begin
                for (int lv = 1; lv <= c_L; lv++) begin
                    for (int k = 0; k < (COMPUTE_CHANNEL_IN_NUM >> lv); k++) begin
                        for (int p = 0; p < LANE_NUM; p++) begin
                            if (lv == 1) begin
                                r_node[node_idx(1, k, p)] <= w_leaf[(2*k)*LANE_NUM + p]
                                                           + w_leaf[(2*k+1)*LANE_NUM + p];
                            end else begin
                                r_node[node_idx(lv, k, p)] <= r_node[node_idx(lv-1, 2*k, p)]
                                                            + r_node[node_idx(lv-1, 2*k+1, p)];
                            end
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld   <= '0;
                    r_first <= '0;
                    r_last  <= '0;
                end else begin
                    r_vld   <= c_L'({r_vld,   bus.in_valid});
                    r_first <= c_L'({r_first, bus.in_first});
                    r_last  <= c_L'({r_last,  bus.in_last});
                end
            end

            always_comb begin
                for (int p = 0; p < LANE_NUM; p++) begin
                    w_tree[p] = r_node[node_idx(c_L, 0, p)];
                end
            end
            assign w_t_vld   = r_vld[c_L-1];
            assign w_t_first = r_first[c_L-1];
            assign w_t_last  = r_last[c_L-1];
        end else begin : g_bypass
            always_comb begin
                for (int p = 0; p < LANE_NUM; p++) begin
                    w_tree[p] = w_leaf[p];
                end
            end
            assign w_t_vld   = bus.in_valid;
            assign w_t_first = bus.in_first;
            assign w_t_last  = bus.in_last;
        end
    endgenerate

    always_comb begin
        w_clamp = 1'b0;
        for (int p = 0; p < LANE_NUM; p++) begin
            w_base[p] = w_t_first ? '0 : c_SW'(r_acc[p]);
            w_sum[p]  = w_base[p] + w_tree[p];
            if ((SATURATE != 0) && (w_sum[p] > c_MAX)) begin
                w_acc_nxt[p] = c_MAX[LANE_WIDTH-1:0];
                w_clamp      = 1'b1;
            end else if ((SATURATE != 0) && (w_sum[p] < c_MIN)) begin
                w_acc_nxt[p] = c_MIN[LANE_WIDTH-1:0];
                w_clamp      = 1'b1;
            end else begin
                w_acc_nxt[p] = w_sum[p][LANE_WIDTH-1:0];
            end
        end
    end

    // Output register sits one stage behind acc, so a last beat followed by a
    // first beat still publishes the finished sum before acc is overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < LANE_NUM; p++) begin
                r_acc[p] <= '0;
            end
            r_sat         <= 1'b0;
            r_done        <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.data_out  <= '0;
            bus.sat_flag  <= 1'b0;
        end else begin
            r_done        <= w_t_vld & w_t_last;
            bus.out_valid <= r_done;
            if (w_t_vld) begin
                for (int p = 0; p < LANE_NUM; p++) begin
                    r_acc[p] <= w_acc_nxt[p];
                end
                r_sat <= (~w_t_first & r_sat) | w_clamp;
            end
            if (r_done) begin
                for (int p = 0; p < LANE_NUM; p++) begin
                    bus.data_out[p*LANE_WIDTH +: LANE_WIDTH] <= r_acc[p];
                end
                bus.sat_flag <= r_sat;
            end
        end
    end
endmodule

`default_nettype wire
